// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: writeback source, FSM states,
// load funct3 encodings and the captured MEM/WB entry.
package wb_pkg;

    typedef enum logic [1:0] {
        ALU  = 2'b00,
        LOAD = 2'b01,
        PC4  = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        FULL      = 2'b01,
        WAIT_LOAD = 2'b10
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Control fields of the captured entry; the datapath value is held separately.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        wb_sel_e    wb_sel;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load lane extraction and sign/zero extension.
// Byte and half selection assume a 32-bit aligned data word.
module load_ext
    import wb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   funct3_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [W-1:0] word_i,
    output logic [W-1:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   value_o = {{(W-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  value_o = {{(W-8){1'b0}}, byte_sel};
            F3_LH:   value_o = {{(W-16){half_sel[15]}}, half_sel};
            F3_LHU:  value_o = {{(W-16){1'b0}}, half_sel};
            default: value_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, source select, load wait and RF write port.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic [1:0]           in_wb_sel,
    input  logic [REG_WIDTH-1:0] in_alu_result,
    input  logic [REG_WIDTH-1:0] in_pc_plus4,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 flush,
    input  logic                 dmem_rvalid,
    input  logic [REG_WIDTH-1:0] dmem_rdata,
    output logic [4:0]           rd,
    output logic [REG_WIDTH-1:0] rd_din,
    output logic                 reg_write,
    output logic                 pend_valid,
    output logic [4:0]           pend_rd
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]          instret
`endif
);

    wb_state_e            state_q, state_d;
    wb_entry_t            entry_q, entry_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic                 accept, retire;
    logic [REG_WIDTH-1:0] load_val, wb_val;

    load_ext #(.W(REG_WIDTH)) u_load_ext (
        .funct3_i  (entry_q.funct3),
        .addr_lo_i (entry_q.addr_lo),
        .word_i    (dmem_rdata),
        .value_o   (load_val)
    );

    // Non-load values are pre-selected at capture; loads take the live response.
    assign wb_val = (entry_q.wb_sel == LOAD) ? load_val : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            entry_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        in_ready = 1'b1;
        retire   = 1'b0;
        case (state_q)
            FULL:      retire = 1'b1;
            WAIT_LOAD: begin
                in_ready = dmem_rvalid;
                retire   = dmem_rvalid;
            end
            default: ;
        endcase

        accept  = in_valid & in_ready & ~flush;
        state_d = state_q;
        entry_d = entry_q;
        data_d  = data_q;

        // A retiring slot may be refilled in the same cycle.
        if (accept) begin
            entry_d.rd        = in_rd;
            entry_d.reg_write = in_reg_write;
            entry_d.funct3    = in_funct3;
            entry_d.addr_lo   = in_addr_lo;
            case (in_wb_sel)
                2'b01:   entry_d.wb_sel = LOAD;
                2'b10:   entry_d.wb_sel = PC4;
                default: entry_d.wb_sel = ALU;
            endcase
            data_d  = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
            state_d = (in_wb_sel == 2'b01) ? WAIT_LOAD : FULL;
        end else if (retire) begin
            state_d = EMPTY;
        end

        reg_write  = retire & entry_q.reg_write & (entry_q.rd != 5'd0);
        rd         = reg_write ? entry_q.rd : 5'd0;
        rd_din     = reg_write ? wb_val : '0;
        pend_valid = (state_q != EMPTY);
        pend_rd    = pend_valid ? entry_q.rd : 5'd0;
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
